// File: rtl/even_event_window_counter_pkg.sv
// ============================================================================
// Module      : even_event_window_counter_pkg
// Description : Shared types, default parameters and the saturating increment
//               used by the even-event window counter and its result slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package even_event_window_counter_pkg;

    localparam int unsigned DEFAULT_WINDOW = 16;
    localparam int unsigned DEFAULT_CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Adds inc to val but never exceeds 2^width-1; width must be 1..31.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic        inc,
                                            input int unsigned width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        if (inc && (val < max_v)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/even_event_window_counter_if.sv
// ============================================================================
// Module      : even_event_window_counter_if
// Description : Valid/ready result port carrying a window count and the
//               sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface even_event_window_counter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             valid;
    logic             ready;
    logic [CNT_W-1:0] count;
    logic             overrun;

    modport master (output valid, output count, output overrun, input ready);
    modport slave  (input valid, input count, input overrun, output ready);
endinterface

`default_nettype wire

// File: rtl/even_event_window_counter_result_slot.sv
// ============================================================================
// Module      : even_event_window_counter_result_slot
// Description : Single-entry valid/ready holding register. A load that finds
//               the slot occupied is dropped and sets a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module even_event_window_counter_result_slot #(
    parameter int unsigned W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clear_i,
    input  wire logic         load_i,
    input  wire logic [W-1:0] data_i,
    input  wire logic         ready_i,
    output logic              valid_o,
    output logic [W-1:0]      data_o,
    output logic              overrun_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         overrun_q;
    logic         slot_free;

    // A transfer in the same cycle frees the slot, giving back-to-back loads.
    assign slot_free = !valid_q || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else if (clear_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (load_i && slot_free) begin
                valid_q <= 1'b1;
                data_q  <= data_i;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            if (load_i && !slot_free) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: rtl/even_event_window_counter.sv
// ============================================================================
// Module      : even_event_window_counter
// Description : Counts detector events over windows of WINDOW enabled bit
//               periods and hands each window count to a result slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module even_event_window_counter
    import even_event_window_counter_pkg::*;
#(
    parameter int unsigned WINDOW = DEFAULT_WINDOW,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   enable_i,
    input  wire logic                   event_in_i,
    input  wire logic                   clear_i,
    output logic                        window_active_o,
    even_event_window_counter_if.master result
);

    localparam int unsigned IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WINDOW - 1);

    state_e           state_q;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] acc_inc;
    logic             window_active_q;
    logic             last_bit;

    always_comb begin
        acc_inc   = CNT_W'(sat_inc(32'(acc_q), event_in_i, CNT_W));
        last_bit  = enable_i && (bit_idx_q == c_last_idx);
        bit_idx_d = bit_idx_q;
        acc_d     = acc_q;
        if (enable_i) begin
            // Window end restarts at bit 0 with no dead cycle in between.
            if (last_bit) begin
                bit_idx_d = '0;
                acc_d     = '0;
            end else begin
                bit_idx_d = bit_idx_q + IDX_W'(1);
                acc_d     = acc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            bit_idx_q       <= '0;
            acc_q           <= '0;
            window_active_q <= 1'b0;
        end else if (clear_i) begin
            state_q         <= IDLE;
            bit_idx_q       <= '0;
            acc_q           <= '0;
            window_active_q <= 1'b0;
        end else begin
            bit_idx_q <= bit_idx_d;
            acc_q     <= acc_d;
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q         <= RUN;
                        window_active_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q         <= RUN;
                    window_active_q <= 1'b1;
                end
                default: begin
                    state_q         <= IDLE;
                    window_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign window_active_o = window_active_q;

    even_event_window_counter_result_slot #(
        .W (CNT_W)
    ) u_result_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear_i),
        .load_i    (last_bit),
        .data_i    (acc_inc),
        .ready_i   (result.ready),
        .valid_o   (result.valid),
        .data_o    (result.count),
        .overrun_o (result.overrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_even_event_window_counter.sv
// ============================================================================
// Module      : tb_even_event_window_counter
// Description : Directed vector bench for the even-event window counter
//               (WINDOW=8 instance plus a WINDOW=300 saturation instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_even_event_window_counter;

    typedef struct {
        logic       en;
        logic       ev;
        logic       rdy;
        logic       clr;
        logic       exp_v;
        logic [7:0] exp_c;
        logic       exp_o;
        logic       exp_a;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en, ev, rdy, clr;
    logic sat_en, sat_ev, sat_rdy;
    logic active, sat_active;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    even_event_window_counter_if #(.CNT_W(8)) res_if ();
    even_event_window_counter_if #(.CNT_W(8)) sat_if ();

    assign res_if.ready = rdy;
    assign sat_if.ready = sat_rdy;

    even_event_window_counter #(.WINDOW(8), .CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (en),
        .event_in_i      (ev),
        .clear_i         (clr),
        .window_active_o (active),
        .result          (res_if)
    );

    even_event_window_counter #(.WINDOW(300), .CNT_W(8)) dut_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (sat_en),
        .event_in_i      (sat_ev),
        .clear_i         (1'b0),
        .window_active_o (sat_active),
        .result          (sat_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic v_in, input logic r, input logic c,
                       input logic xv, input logic [7:0] xc, input logic xo, input logic xa);
        vec_t t;
        t.en = e; t.ev = v_in; t.rdy = r; t.clr = c;
        t.exp_v = xv; t.exp_c = xc; t.exp_o = xo; t.exp_a = xa;
        vecs.push_back(t);
    endtask

    // Eight enabled bits; expected outputs after bit 0, bits 1..6 and bit 7.
    task automatic add_win(input logic [7:0] evm, input logic [7:0] rdym,
                           input logic v0, input logic [7:0] c0,
                           input logic vm, input logic [7:0] cm, input logic om,
                           input logic ve, input logic [7:0] ce, input logic oe);
        for (int b = 0; b < 8; b++) begin
            if (b == 0)      add(1'b1, evm[b], rdym[b], 1'b0, v0, c0, om, 1'b1);
            else if (b == 7) add(1'b1, evm[b], rdym[b], 1'b0, ve, ce, oe, 1'b1);
            else             add(1'b1, evm[b], rdym[b], 1'b0, vm, cm, om, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; ev = 0; rdy = 0; clr = 0;
        sat_en = 0; sat_ev = 0; sat_rdy = 1;

        // Basic window: events on bits 1,3,7 -> 3, single-cycle valid.
        add_win(8'b1000_1010, 8'hFF, 0, 8'd0, 0, 8'd0, 0, 1, 8'd3, 0);
        // Consume 3 at bit 0, then hold 4.
        add_win(8'b0000_1111, 8'h01, 0, 8'd3, 0, 8'd3, 0, 1, 8'd4, 0);
        // 4 held; transfer coincides with window end loading 6.
        add_win(8'b0011_1111, 8'h80, 1, 8'd4, 1, 8'd4, 0, 1, 8'd6, 0);
        // Consume 6, then load 5 and hold it.
        add_win(8'b0001_1111, 8'h01, 0, 8'd6, 0, 8'd6, 0, 1, 8'd5, 0);
        // Count 2 is dropped while 5 is pending.
        add_win(8'b0001_0100, 8'h00, 1, 8'd5, 1, 8'd5, 0, 1, 8'd5, 1);
        // Transfer 5; event with enable=0 is ignored; overrun stays.
        add(1'b0, 1'b1, 1'b1, 1'b0, 0, 8'd5, 1, 1);
        add_win(8'b0000_0001, 8'h00, 0, 8'd5, 0, 8'd5, 1, 1, 8'd1, 1);
        // Clear wins over enable/event.
        add(1'b1, 1'b1, 1'b0, 1'b1, 0, 8'd0, 0, 0);
        add_win(8'b0000_0001, 8'h00, 0, 8'd0, 0, 8'd0, 0, 1, 8'd1, 0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd1, 0, 1);

        #23;
        chk("reset.valid",   res_if.valid,   0);
        chk("reset.count",   res_if.count,   0);
        chk("reset.overrun", res_if.overrun, 0);
        chk("reset.active",  active,         0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; ev = vecs[i].ev; rdy = vecs[i].rdy; clr = vecs[i].clr;
            tick();
            chk($sformatf("row%0d.valid", i),   res_if.valid,   vecs[i].exp_v);
            chk($sformatf("row%0d.count", i),   res_if.count,   vecs[i].exp_c);
            chk($sformatf("row%0d.overrun", i), res_if.overrun, vecs[i].exp_o);
            chk($sformatf("row%0d.active", i),  active,         vecs[i].exp_a);
        end

        // Gapped enable: events on disabled cycles must not count; 2 events total.
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 0);
            ev = en ? ((i == 0) || (i == 4)) : 1'b1;
            tick();
            chk($sformatf("gap%0d.valid", i), res_if.valid, (i == 14));
            if (i == 14) chk("gap.count", res_if.count, 2);
        end

        // Asynchronous reset mid-window takes effect without a clock edge.
        en = 1'b1; ev = 1'b1; rdy = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.valid",   res_if.valid,   0);
        chk("areset.count",   res_if.count,   0);
        chk("areset.overrun", res_if.overrun, 0);
        chk("areset.active",  active,         0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ev = (b == 0) || (b == 7);
            tick();
            if (b == 0) chk("areset.restart_active", active, 1);
            chk($sformatf("areset.bit%0d.valid", b), res_if.valid, (b == 7));
        end
        chk("areset.window_count", res_if.count, 2);
        en = 1'b0; ev = 1'b0;

        // Saturation: 300 events in a 300-bit window clamp at 255.
        sat_en = 1'b1; sat_ev = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 298) chk("sat.valid_before_end", sat_if.valid, 0);
        end
        chk("sat.active", sat_active, 1);
        chk("sat.valid", sat_if.valid, 1);
        chk("sat.count", sat_if.count, 255);
        sat_en = 1'b0;
        tick();
        chk("sat.valid_after_transfer", sat_if.valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
